// File: rtl/pic_seq_pkg.sv
// Shared types and constants for the 8259A host sequencer.
// Optional IMR readback check is enabled by PIC_SEQ_IMR_VERIFY_EN.
package pic_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ICW1,
    S_ICW2,
    S_ICW3,
    S_ICW4,
    S_OCW1,
    S_IMRCHK,
    S_READY,
    S_ACK1,
    S_ACK2,
    S_WAIT_EOI,
    S_EOI
  } state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_SETUP,
    B_STROBE,
    B_HOLD,
    B_RECOVER
  } phase_e;

  typedef enum logic [1:0] {
    K_WR,
    K_RD,
    K_INTA
  } kind_e;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;
  localparam logic [7:0] ICW1_FIXED  = 8'h11;
  localparam logic [7:0] ICW4_FIXED  = 8'h01;

  function automatic logic [7:0] icw1_word(
    input logic ltim,
    input logic sngl
  );
    return ICW1_FIXED | {4'b0000, ltim, 1'b0, sngl, 1'b0};
  endfunction

  function automatic logic [7:0] icw4_word(
    input logic aeoi
  );
    return ICW4_FIXED | {6'b000000, aeoi, 1'b0};
  endfunction

endpackage

// File: rtl/pic_host_sequencer_if.sv
// PIC-side pin bundle between the host sequencer and the 8259A core.
// The master modport is the sequencer side.
interface pic_host_sequencer_if;
  logic       INT;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic       A0;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       INTA_n;

  modport master (
    input  INT, D_in,
    output D_out, D_oe, A0, CS_n, WR_n, RD_n, INTA_n
  );

  modport slave (
    output INT, D_in,
    input  D_out, D_oe, A0, CS_n, WR_n, RD_n, INTA_n
  );
endinterface

// File: rtl/pic_bus_cycle.sv
// One PIC bus transaction (write, read or INTA pulse) per go.
// done is raised in the last recover cycle so a new go chains back-to-back.
module pic_bus_cycle
  import pic_seq_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int RECOVERY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  kind_e      kind,
  input  logic       a0,
  input  logic [7:0] data,
  output logic       done,
  output logic       sample,
  pic_host_sequencer_if.master bus
);

  localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] RC_LAST = 8'(RECOVERY - 1);

  phase_e     phase, phase_nx;
  logic [7:0] cnt, cnt_nx;
  kind_e      kind_r;
  logic       a0_r;
  logic [7:0] data_r;
  logic       active;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= B_IDLE;
      cnt    <= '0;
      kind_r <= K_WR;
      a0_r   <= 1'b0;
      data_r <= '0;
    end else begin
      phase <= phase_nx;
      cnt   <= cnt_nx;
      if (go) begin
        kind_r <= kind;
        a0_r   <= a0;
        data_r <= data;
      end
    end
  end

  always_comb begin
    phase_nx = phase;
    cnt_nx   = cnt + 8'd1;
    done     = 1'b0;
    sample   = 1'b0;
    unique case (phase)
      B_IDLE: begin
        cnt_nx = '0;
        if (go) phase_nx = B_SETUP;
      end
      B_SETUP: begin
        cnt_nx   = '0;
        phase_nx = B_STROBE;
      end
      B_STROBE: begin
        if (cnt == PW_LAST) begin
          cnt_nx   = '0;
          sample   = (kind_r != K_WR);
          // INTA has no hold phase
          phase_nx = (kind_r == K_INTA) ? B_RECOVER : B_HOLD;
        end
      end
      B_HOLD: begin
        cnt_nx   = '0;
        phase_nx = B_RECOVER;
      end
      B_RECOVER: begin
        if (cnt == RC_LAST) begin
          cnt_nx   = '0;
          done     = 1'b1;
          phase_nx = go ? B_SETUP : B_IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        phase_nx = B_IDLE;
      end
    endcase
  end

  assign active = (phase == B_SETUP) || (phase == B_STROBE)
               || (phase == B_HOLD);

  assign bus.CS_n   = ~(active && (kind_r != K_INTA));
  assign bus.D_oe   = active && (kind_r == K_WR);
  assign bus.WR_n   = ~((phase == B_STROBE) && (kind_r == K_WR));
  assign bus.RD_n   = ~((phase == B_STROBE) && (kind_r == K_RD));
  assign bus.INTA_n = ~((phase == B_STROBE) && (kind_r == K_INTA));
  assign bus.A0     = a0_r;
  assign bus.D_out  = data_r;

endmodule

// File: rtl/pic_host_sequencer.sv
// Host bus master: programs the 8259A, runs INTA cycles and issues EOI.
// Define PIC_SEQ_IMR_VERIFY_EN to add an IMR readback after OCW1.
module pic_host_sequencer
  import pic_seq_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int RECOVERY = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       cfg_sngl,
  input  logic       cfg_ltim,
  input  logic       cfg_aeoi,
  input  logic [4:0] cfg_vec_base,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_imr,
  input  logic       eoi_req,
  pic_host_sequencer_if.master bus,
  output logic       busy,
  output logic       init_done,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       cfg_err
);

  state_e     state, state_nx;
  logic       go, done, sample;
  kind_e      kind;
  logic       a0;
  logic [7:0] wdata;
  logic       int_q1, int_s;
  logic       sngl_r, aeoi_r;
  logic [4:0] vec_base_r;
  logic [7:0] icw3_r, imr_r;
  logic       start_acc, init_end, capture;

  pic_bus_cycle #(
    .PULSE_W (PULSE_W),
    .RECOVERY(RECOVERY)
  ) u_bus (
    .clk   (CLK),
    .rst   (RESET),
    .go    (go),
    .kind  (kind),
    .a0    (a0),
    .data  (wdata),
    .done  (done),
    .sample(sample),
    .bus   (bus)
  );

  assign start_acc = start && ((state == S_IDLE) || (state == S_READY));
  assign init_end  = ((state == S_OCW1) || (state == S_IMRCHK))
                  && (state_nx == S_READY);
  assign capture   = (state == S_ACK2) && sample;
  assign busy      = !((state == S_IDLE) || (state == S_READY)
                  || (state == S_WAIT_EOI));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      int_q1     <= 1'b0;
      int_s      <= 1'b0;
      init_done  <= 1'b0;
      vec_valid  <= 1'b0;
      vec        <= '0;
      sngl_r     <= 1'b0;
      aeoi_r     <= 1'b0;
      vec_base_r <= '0;
      icw3_r     <= '0;
      imr_r      <= '0;
    end else begin
      state     <= state_nx;
      int_q1    <= bus.INT;
      int_s     <= int_q1;
      vec_valid <= capture;
      if (capture) vec <= bus.D_in;
      if (start_acc) begin
        sngl_r     <= cfg_sngl;
        aeoi_r     <= cfg_aeoi;
        vec_base_r <= cfg_vec_base;
        icw3_r     <= cfg_icw3;
        imr_r      <= cfg_imr;
        init_done  <= 1'b0;
      end else if (init_end) begin
        init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    kind     = K_WR;
    a0       = 1'b1;
    wdata    = 8'h00;
    // ICW1 uses live config: the registered copies land a cycle later
    if (start_acc) begin
      state_nx = S_ICW1;
      go       = 1'b1;
      a0       = 1'b0;
      wdata    = icw1_word(cfg_ltim, cfg_sngl);
    end else begin
      unique case (state)
        S_IDLE: ;
        S_ICW1: if (done) begin
          state_nx = S_ICW2;
          go       = 1'b1;
          wdata    = {vec_base_r, 3'b000};
        end
        S_ICW2: if (done) begin
          go = 1'b1;
          if (sngl_r) begin
            state_nx = S_ICW4;
            wdata    = icw4_word(aeoi_r);
          end else begin
            state_nx = S_ICW3;
            wdata    = icw3_r;
          end
        end
        S_ICW3: if (done) begin
          state_nx = S_ICW4;
          go       = 1'b1;
          wdata    = icw4_word(aeoi_r);
        end
        S_ICW4: if (done) begin
          state_nx = S_OCW1;
          go       = 1'b1;
          wdata    = imr_r;
        end
        S_OCW1: if (done) begin
`ifdef PIC_SEQ_IMR_VERIFY_EN
          state_nx = S_IMRCHK;
          go       = 1'b1;
          kind     = K_RD;
`else
          state_nx = S_READY;
`endif
        end
        S_IMRCHK: if (done) state_nx = S_READY;
        S_READY: if (int_s) begin
          state_nx = S_ACK1;
          go       = 1'b1;
          kind     = K_INTA;
        end
        S_ACK1: if (done) begin
          state_nx = S_ACK2;
          go       = 1'b1;
          kind     = K_INTA;
        end
        S_ACK2: if (done) begin
          state_nx = aeoi_r ? S_READY : S_WAIT_EOI;
        end
        S_WAIT_EOI: if (eoi_req) begin
          state_nx = S_EOI;
          go       = 1'b1;
          a0       = 1'b0;
          wdata    = OCW2_NS_EOI;
        end
        S_EOI: if (done) state_nx = S_READY;
        default: state_nx = S_IDLE;
      endcase
    end
  end

`ifdef PIC_SEQ_IMR_VERIFY_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cfg_err <= 1'b0;
    end else if ((state == S_IMRCHK) && sample
                 && (bus.D_in != imr_r)) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer with write/vector scoreboards.
// Build with PIC_SEQ_IMR_VERIFY_EN to cover the IMR readback path.
module tb_pic_host_sequencer;

`ifdef PIC_SEQ_IMR_VERIFY_EN
  localparam int XTRA = 5;
`else
  localparam int XTRA = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic       cfg_sngl = 1'b0;
  logic       cfg_ltim = 1'b0;
  logic       cfg_aeoi = 1'b0;
  logic [4:0] cfg_vec_base = '0;
  logic [7:0] cfg_icw3 = '0;
  logic [7:0] cfg_imr = '0;
  logic       eoi_req = 1'b0;
  logic       busy, init_done, vec_valid, cfg_err;
  logic [7:0] vec;

  pic_host_sequencer_if pif ();

  pic_host_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .cfg_sngl    (cfg_sngl),
    .cfg_ltim    (cfg_ltim),
    .cfg_aeoi    (cfg_aeoi),
    .cfg_vec_base(cfg_vec_base),
    .cfg_icw3    (cfg_icw3),
    .cfg_imr     (cfg_imr),
    .eoi_req     (eoi_req),
    .bus         (pif),
    .busy        (busy),
    .init_done   (init_done),
    .vec_valid   (vec_valid),
    .vec         (vec),
    .cfg_err     (cfg_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] vec_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: completed writes and captured vectors vs. scoreboards
  int         wlow = 0;
  logic [7:0] wd;
  logic       wa, wbad;
  logic       prev_inta = 1'b1;
  int         inta_cnt = 0;
  logic [8:0] e;

  always @(negedge CLK) begin
    if (RESET) begin
      wlow      = 0;
      prev_inta = 1'b1;
    end else begin
      if (pif.INTA_n === 1'b0 && prev_inta === 1'b1) inta_cnt++;
      prev_inta = pif.INTA_n;
      if (pif.WR_n === 1'b0) begin
        wlow++;
        wd   = pif.D_out;
        wa   = pif.A0;
        wbad = pif.CS_n | ~pif.D_oe;
      end else if (wlow != 0) begin
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_word", {23'd0, wa, wd}, {23'd0, e});
          chk("wr_width", 32'(wlow), 2);
          chk("wr_cs_oe", {31'd0, wbad}, 0);
        end
        wlow = 0;
      end
      if (vec_valid === 1'b1) begin
        chk("vec_expected", 32'(vec_q.size() != 0), 1);
        if (vec_q.size() != 0) chk("vec", {24'd0, vec}, {24'd0, vec_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_start(input logic sngl, input logic ltim,
                          input logic aeoi, input logic [4:0] vb,
                          input logic [7:0] i3, input logic [7:0] imr);
    cfg_sngl     = sngl;
    cfg_ltim     = ltim;
    cfg_aeoi     = aeoi;
    cfg_vec_base = vb;
    cfg_icw3     = i3;
    cfg_imr      = imr;
    exp_q.push_back({1'b0, 3'b000, 1'b1, ltim, 1'b0, sngl, 1'b1});
    exp_q.push_back({1'b1, vb, 3'b000});
    if (!sngl) exp_q.push_back({1'b1, i3});
    exp_q.push_back({1'b1, 6'd0, aeoi, 1'b1});
    exp_q.push_back({1'b1, imr});
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_init(input string tag, input int exp_n);
    int n;
    n = 1;
    while (init_done !== 1'b1 && n < 80) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_irq(input logic [7:0] v);
    int base, k;
    pif.D_in = v;
    vec_q.push_back(v);
    base    = inta_cnt;
    pif.INT = 1'b1;
    k = 0;
    while (pif.INTA_n !== 1'b0 && k < 30) begin
      cyc(1);
      k++;
    end
    chk("inta_seen", {31'd0, pif.INTA_n}, 0);
    pif.INT = 1'b0;
    cyc(12);
    chk("inta_pulses", 32'(inta_cnt - base), 2);
    chk("vec_reg", {24'd0, vec}, {24'd0, v});
    chk("vec_q_empty", 32'(vec_q.size()), 0);
  endtask

  task automatic do_eoi(input logic expect_write);
    if (expect_write) exp_q.push_back({1'b0, 8'h20});
    eoi_req = 1'b1;
    cyc(1);
    eoi_req = 1'b0;
    cyc(10);
    chk("eoi_q_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int base;
    pif.INT  = 1'b0;
    pif.D_in = 8'h00;

    cyc(3);
    chk("rst_strobes", {28'd0, pif.CS_n, pif.WR_n, pif.RD_n, pif.INTA_n},
        32'hF);
    chk("rst_flags", {26'd0, pif.D_oe, pif.A0, busy, init_done,
        vec_valid, cfg_err}, 0);
    chk("rst_data", {16'd0, pif.D_out, vec}, 0);
    RESET = 1'b0;
    cyc(2);

    // Full init with cascade word, EOI-driven servicing
    pif.D_in = 8'hF0;
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h04, 8'hF0);
    chk("busy_init", {31'd0, busy}, 1);
    wait_init("init_cycles_cascade", 26 + XTRA);
    cyc(2);
    chk("init_q_empty", 32'(exp_q.size()), 0);
    chk("cfg_err_clean", {31'd0, cfg_err}, 0);
    chk("busy_ready", {31'd0, busy}, 0);

    do_irq(8'h43);
    chk("busy_wait_eoi", {31'd0, busy}, 0);
    base    = inta_cnt;
    pif.INT = 1'b1;
    cyc(10);
    pif.INT = 1'b0;
    cyc(4);
    chk("int_ignored_wait_eoi", 32'(inta_cnt - base), 0);
    do_eoi(1'b1);
    do_irq(8'h55);
    do_eoi(1'b1);

    // Single mode with auto-EOI, re-init from READY
    pif.D_in = 8'h0F;
    do_start(1'b1, 1'b0, 1'b1, 5'h10, 8'hAA, 8'h0F);
    chk("init_done_cleared", {31'd0, init_done}, 0);
    wait_init("init_cycles_single", 21 + XTRA);
    cyc(2);
    chk("init_q_empty_sngl", 32'(exp_q.size()), 0);
    do_irq(8'h77);
    do_eoi(1'b0);
    do_irq(8'h78);

    // Reset in the middle of the ICW2 strobe
    begin
      int k;
      cfg_sngl = 1'b0;
      cfg_ltim = 1'b1;
      cfg_aeoi = 1'b0;
      exp_q.push_back({1'b0, 8'h19});
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      k = 0;
      while (!(pif.WR_n === 1'b0 && pif.A0 === 1'b1) && k < 30) begin
        cyc(1);
        k++;
      end
      chk("icw2_strobe_seen", {30'd0, pif.WR_n, pif.A0}, 1);
      RESET = 1'b1;
      cyc(1);
      chk("rst_mid_write", {27'd0, pif.WR_n, pif.CS_n, pif.D_oe, busy,
          init_done}, 32'h18);
      RESET = 1'b0;
      cyc(2);
      chk("rst_q_empty", 32'(exp_q.size()), 0);
    end

`ifdef PIC_SEQ_IMR_VERIFY_EN
    pif.D_in = 8'hF1;
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h04, 8'hF0);
    wait_init("init_cycles_bad_imr", 31);
    chk("cfg_err_set", {31'd0, cfg_err}, 1);
    cyc(2);
    pif.D_in = 8'hF0;
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h04, 8'hF0);
    wait_init("init_cycles_reinit", 31);
    chk("cfg_err_sticky", {31'd0, cfg_err}, 1);
`else
    pif.D_in = 8'hF1;
    do_start(1'b0, 1'b1, 1'b0, 5'h08, 8'h04, 8'hF0);
    wait_init("init_cycles_after_rst", 26);
    chk("cfg_err_tied", {31'd0, cfg_err}, 0);
`endif
    cyc(2);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
